// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding, wait-state limit, byte-lane width
// and a helper for the byte-to-word address shift.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int WAIT_MAX = 15;
    localparam int LANE_W   = 8;

    // Number of low PADDR bits that select a byte within one data word.
    function automatic int byte_shift(input int data_width);
        return $clog2(data_width / LANE_W);
    endfunction

endpackage

// File: rtl/apb_sp_ram.sv
// Single-port byte-lane RAM: synchronous byte-enable write, one registered read port
// whose output register clears on reset (array contents are never reset).
module apb_sp_ram
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int AW         = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_en,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH/LANE_W-1:0] be,
    input  logic [AW-1:0]                addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int NB = DATA_WIDTH / LANE_W;

    // One independent array per byte lane keeps each write enable to a single block.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [LANE_W-1:0] mem_q [0:DEPTH-1];
            logic [LANE_W-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && be[gi]) begin
                    mem_q[addr] <= wdata[gi*LANE_W +: LANE_W];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem_q[addr];
                end
            end

            assign rdata[gi*LANE_W +: LANE_W] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/apb_mem_slave.sv
// APB word-memory slave with configurable wait states and byte strobes.
// Define APB_SLVERR_EN to flag out-of-range accesses with PSLVERR; otherwise addresses wrap.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/LANE_W-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR
);

    localparam int         BSHIFT = byte_shift(DATA_WIDTH);
    localparam int         RAM_AW = $clog2(DEPTH);
    localparam logic [3:0] WLOAD  = 4'((WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES);

    apb_state_e            state_q;
    logic [3:0]            wcnt_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [RAM_AW-1:0]     ram_addr;
    logic                  oor;
    logic                  setup;
    logic                  ready;
    logic                  complete;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // The range test uses the full-width index, before it is cut down to RAM address bits.
    assign word_idx = PADDR >> BSHIFT;
    assign ram_addr = word_idx[RAM_AW-1:0];

`ifdef APB_SLVERR_EN
    assign oor = (word_idx >= ADDR_WIDTH'(DEPTH));
`else
    logic idx_unused;
    assign oor        = 1'b0;
    assign idx_unused = ^word_idx[ADDR_WIDTH-1:RAM_AW];
`endif

    assign setup    = (state_q == IDLE) && PSEL && !PENABLE;
    assign ready    = (state_q == ACCESS) && (wcnt_q == 4'd0);
    assign complete = ready && PSEL && PENABLE;
    assign rd_en    = setup && !oor;
    assign wr_en    = complete && PWRITE && !err_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // PSEL with PENABLE already high has skipped setup and is ignored.
                    if (PSEL && !PENABLE) begin
                        state_q <= ACCESS;
                        wcnt_q  <= WLOAD;
                        err_q   <= oor;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (PENABLE) begin
                        if (wcnt_q == 4'd0) begin
                            state_q <= IDLE;
                        end else begin
                            wcnt_q <= wcnt_q - 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    apb_sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clk   (PCLK),
        .rst   (PRESET),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .be    (PSTRB),
        .addr  (ram_addr),
        .wdata (PWDATA),
        .rdata (ram_rdata)
    );

    assign PREADY = ready;
    assign PRDATA = (ready && !PWRITE && !err_q) ? ram_rdata : '0;

`ifdef APB_SLVERR_EN
    assign PSLVERR = ready && err_q;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule
